blit_ptr_step: RTL and testbench

Blitter address-pointer register and stepping unit. Holds the A1 and A2 pixel pointers, A1 fractional parts, increments, steps and loop counts. Walks the inner (pixel) and outer (line) loops of a blit, updating the pointers once per acknowledged pixel. Sits directly upstream of the address-B mux: its `a1_x/a1_y/a2_x/a2_y/a1_frac_x/a1_frac_y` outputs drive that mux's inputs.

---
 rtl/blit_ptr_step.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_blit_ptr_step.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/blit_ptr_step.sv
// ---------------------------------------------------------------------------
// blit_ptr_step
//
// Blitter address-pointer register and stepping unit.  Holds the A1 and A2
// pixel pointers, the A1 fractional parts, the per-pixel increments, the
// per-line steps and the inner/outer loop counts, and walks the pixel (inner)
// and line (outer) loops of a blit.  The pointers advance once for every
// acknowledged pixel, and once more by the line step between lines.
//
// Ports
//   sys_clk              : single clock, rising edge
//   resetl               : asynchronous, active-low reset
//   ld_en                : register-load strobe, one register per cycle
//   ld_sel[2:0]          : load target (A1_PIXEL .. COUNT), data {upper,lower}
//   ld_data[31:0]        : load data
//   start                : single-cycle pulse that begins a blit
//   pix_ack              : downstream consumed the current pixel address
//   pix_req              : pointers are valid for a pixel access
//   busy                 : blit in progress (pixel or step cycles)
//   done                 : one-cycle completion pulse
//   a1_x/a1_y/a2_x/a2_y  : integer pointers, feed the address-B mux
//   a1_frac_x/a1_frac_y  : A1 fractional parts, feed the address-B mux
// ---------------------------------------------------------------------------
module blit_ptr_step (
    input  logic        sys_clk,
    input  logic        resetl,
    input  logic        ld_en,
    input  logic [2:0]  ld_sel,
    input  logic [31:0] ld_data,
    input  logic        start,
    input  logic        pix_ack,
    output logic        pix_req,
    output logic        busy,
    output logic        done,
    output logic [15:0] a1_x,
    output logic [15:0] a1_y,
    output logic [15:0] a2_x,
    output logic [15:0] a2_y,
    output logic [15:0] a1_frac_x,
    output logic [15:0] a1_frac_y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PIXEL = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } stateT;

    localparam logic [2:0] SEL_A1_PIXEL  = 3'd0;
    localparam logic [2:0] SEL_A1_FPIXEL = 3'd1;
    localparam logic [2:0] SEL_A1_INC    = 3'd2;
    localparam logic [2:0] SEL_A1_FINC   = 3'd3;
    localparam logic [2:0] SEL_A1_STEP   = 3'd4;
    localparam logic [2:0] SEL_A2_PIXEL  = 3'd5;
    localparam logic [2:0] SEL_A2_STEP   = 3'd6;
    localparam logic [2:0] SEL_COUNT     = 3'd7;

    stateT       state_q, state_d;

    logic [15:0] a1X_q, a1X_d;
    logic [15:0] a1Y_q, a1Y_d;
    logic [15:0] a1FracX_q, a1FracX_d;
    logic [15:0] a1FracY_q, a1FracY_d;
    logic [15:0] incX_q, incX_d;
    logic [15:0] incY_q, incY_d;
    logic [15:0] fincX_q, fincX_d;
    logic [15:0] fincY_q, fincY_d;
    logic [15:0] a1StepX_q, a1StepX_d;
    logic [15:0] a1StepY_q, a1StepY_d;
    logic [15:0] a2X_q, a2X_d;
    logic [15:0] a2Y_q, a2Y_d;
    logic [15:0] a2StepX_q, a2StepX_d;
    logic [15:0] a2StepY_q, a2StepY_d;
    logic [15:0] innerCnt_q, innerCnt_d;
    logic [15:0] outerCnt_q, outerCnt_d;
    logic [15:0] icnt_q, icnt_d;
    logic [15:0] ocnt_q, ocnt_d;

    logic        pixReq_q, pixReq_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [31:0] a1XSum;
    logic [31:0] a1YSum;

    // The per-pixel A1 advance treats integer and fraction as one 32-bit
    // fixed-point number, so a fraction overflow carries into the integer.
    always_comb begin
        a1XSum = {a1X_q, a1FracX_q} + {incX_q, fincX_q};
        a1YSum = {a1Y_q, a1FracY_q} + {incY_q, fincY_q};
    end

    // Next-state logic for the FSM and every datapath register.  Everything
    // holds by default; loads are only honoured in IDLE so a running blit can
    // never see its pointers or counts change underneath it.  A start in the
    // same cycle as a COUNT load reads the counts as they were before the
    // load, because it looks at the current register values.
    always_comb begin
        state_d    = state_q;
        a1X_d      = a1X_q;
        a1Y_d      = a1Y_q;
        a1FracX_d  = a1FracX_q;
        a1FracY_d  = a1FracY_q;
        incX_d     = incX_q;
        incY_d     = incY_q;
        fincX_d    = fincX_q;
        fincY_d    = fincY_q;
        a1StepX_d  = a1StepX_q;
        a1StepY_d  = a1StepY_q;
        a2X_d      = a2X_q;
        a2Y_d      = a2Y_q;
        a2StepX_d  = a2StepX_q;
        a2StepY_d  = a2StepY_q;
        innerCnt_d = innerCnt_q;
        outerCnt_d = outerCnt_q;
        icnt_d     = icnt_q;
        ocnt_d     = ocnt_q;

        case (state_q)
            IDLE: begin
                if (ld_en) begin
                    case (ld_sel)
                        SEL_A1_PIXEL: begin
                            a1Y_d = ld_data[31:16];
                            a1X_d = ld_data[15:0];
                        end
                        SEL_A1_FPIXEL: begin
                            a1FracY_d = ld_data[31:16];
                            a1FracX_d = ld_data[15:0];
                        end
                        SEL_A1_INC: begin
                            incY_d = ld_data[31:16];
                            incX_d = ld_data[15:0];
                        end
                        SEL_A1_FINC: begin
                            fincY_d = ld_data[31:16];
                            fincX_d = ld_data[15:0];
                        end
                        SEL_A1_STEP: begin
                            a1StepY_d = ld_data[31:16];
                            a1StepX_d = ld_data[15:0];
                        end
                        SEL_A2_PIXEL: begin
                            a2Y_d = ld_data[31:16];
                            a2X_d = ld_data[15:0];
                        end
                        SEL_A2_STEP: begin
                            a2StepY_d = ld_data[31:16];
                            a2StepX_d = ld_data[15:0];
                        end
                        SEL_COUNT: begin
                            outerCnt_d = ld_data[31:16];
                            innerCnt_d = ld_data[15:0];
                        end
                        default: begin
                        end
                    endcase
                end

                // An empty blit (either count zero) finishes without ever
                // requesting a pixel.
                if (start) begin
                    if ((innerCnt_q != 16'd0) && (outerCnt_q != 16'd0)) begin
                        icnt_d  = innerCnt_q;
                        ocnt_d  = outerCnt_q;
                        state_d = PIXEL;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            PIXEL: begin
                if (pix_ack) begin
                    {a1X_d, a1FracX_d} = a1XSum;
                    {a1Y_d, a1FracY_d} = a1YSum;
                    a2X_d  = a2X_q + 16'd1;
                    icnt_d = icnt_q - 16'd1;
                    if (icnt_q == 16'd1) begin
                        if (ocnt_q == 16'd1) begin
                            state_d = DONE;
                        end else begin
                            state_d = STEP;
                        end
                    end
                end
            end

            // Line boundary: integer parts move by the line step (fractions
            // untouched) and the inner counter starts the next line.
            STEP: begin
                a1X_d   = a1X_q + a1StepX_q;
                a1Y_d   = a1Y_q + a1StepY_q;
                a2X_d   = a2X_q + a2StepX_q;
                a2Y_d   = a2Y_q + a2StepY_q;
                icnt_d  = innerCnt_q;
                ocnt_d  = ocnt_q - 16'd1;
                state_d = PIXEL;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe, with no input-to-output path.
    always_comb begin
        pixReq_d = (state_d == PIXEL);
        busy_d   = (state_d == PIXEL) || (state_d == STEP);
        done_d   = (state_d == DONE);
    end

    // All state, including the registered status outputs, lives here and
    // clears asynchronously to zero / IDLE.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_q    <= IDLE;
            a1X_q      <= 16'd0;
            a1Y_q      <= 16'd0;
            a1FracX_q  <= 16'd0;
            a1FracY_q  <= 16'd0;
            incX_q     <= 16'd0;
            incY_q     <= 16'd0;
            fincX_q    <= 16'd0;
            fincY_q    <= 16'd0;
            a1StepX_q  <= 16'd0;
            a1StepY_q  <= 16'd0;
            a2X_q      <= 16'd0;
            a2Y_q      <= 16'd0;
            a2StepX_q  <= 16'd0;
            a2StepY_q  <= 16'd0;
            innerCnt_q <= 16'd0;
            outerCnt_q <= 16'd0;
            icnt_q     <= 16'd0;
            ocnt_q     <= 16'd0;
            pixReq_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a1X_q      <= a1X_d;
            a1Y_q      <= a1Y_d;
            a1FracX_q  <= a1FracX_d;
            a1FracY_q  <= a1FracY_d;
            incX_q     <= incX_d;
            incY_q     <= incY_d;
            fincX_q    <= fincX_d;
            fincY_q    <= fincY_d;
            a1StepX_q  <= a1StepX_d;
            a1StepY_q  <= a1StepY_d;
            a2X_q      <= a2X_d;
            a2Y_q      <= a2Y_d;
            a2StepX_q  <= a2StepX_d;
            a2StepY_q  <= a2StepY_d;
            innerCnt_q <= innerCnt_d;
            outerCnt_q <= outerCnt_d;
            icnt_q     <= icnt_d;
            ocnt_q     <= ocnt_d;
            pixReq_q   <= pixReq_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign pix_req   = pixReq_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign a1_x      = a1X_q;
    assign a1_y      = a1Y_q;
    assign a2_x      = a2X_q;
    assign a2_y      = a2Y_q;
    assign a1_frac_x = a1FracX_q;
    assign a1_frac_y = a1FracY_q;

endmodule

// File: tb/tb_blit_ptr_step.sv
// ---------------------------------------------------------------------------
// tb_blit_ptr_step
//
// Directed bench for blit_ptr_step: reset values, register loads (and loads
// ignored while busy), a 3x2 walk with line steps, fraction carry, stall,
// 16-bit wrap, zero-count blits, start/load in the same cycle and an
// asynchronous reset in the middle of a blit.
// ---------------------------------------------------------------------------
module tb_blit_ptr_step;

    logic        sys_clk;
    logic        resetl;
    logic        ld_en;
    logic [2:0]  ld_sel;
    logic [31:0] ld_data;
    logic        start;
    logic        pix_ack;
    logic        pix_req;
    logic        busy;
    logic        done;
    logic [15:0] a1_x;
    logic [15:0] a1_y;
    logic [15:0] a2_x;
    logic [15:0] a2_y;
    logic [15:0] a1_frac_x;
    logic [15:0] a1_frac_y;

    int compared;
    int mismatched;

    blit_ptr_step dut (
        .sys_clk   (sys_clk),
        .resetl    (resetl),
        .ld_en     (ld_en),
        .ld_sel    (ld_sel),
        .ld_data   (ld_data),
        .start     (start),
        .pix_ack   (pix_ack),
        .pix_req   (pix_req),
        .busy      (busy),
        .done      (done),
        .a1_x      (a1_x),
        .a1_y      (a1_y),
        .a2_x      (a2_x),
        .a2_y      (a2_y),
        .a1_frac_x (a1_frac_x),
        .a1_frac_y (a1_frac_y)
    );

    // Free-running 100 MHz-style clock, rising edges at 5, 15, 25 ...
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Advance one rising edge and settle just after it, so inputs change
    // and outputs are sampled away from the active edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One immediate-assertion comparison; counts and reports misses.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Single-cycle register load.
    task automatic applyStimulus(input logic [2:0] sel, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_data = data;
        tick();
        ld_en   = 1'b0;
    endtask

    int walkX    [8] = '{1, 2, 3, 0, 1, 2, 3, 3};
    int walkY    [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
    int walkReq  [8] = '{1, 1, 0, 1, 1, 1, 0, 0};
    int walkBusy [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    int walkDone [8] = '{0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        compared   = 0;
        mismatched = 0;
        resetl     = 1'b0;
        ld_en      = 1'b0;
        ld_sel     = 3'd0;
        ld_data    = 32'd0;
        start      = 1'b0;
        pix_ack    = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        checkOutput("rst_a1x", {16'd0, a1_x}, 32'd0);
        checkOutput("rst_a1y", {16'd0, a1_y}, 32'd0);
        checkOutput("rst_a2x", {16'd0, a2_x}, 32'd0);
        checkOutput("rst_a2y", {16'd0, a2_y}, 32'd0);
        checkOutput("rst_frac", {a1_frac_y, a1_frac_x}, 32'd0);
        checkOutput("rst_flags", {29'd0, pix_req, busy, done}, 32'd0);
        resetl = 1'b1;
        tick();

        // ---------------- load ----------------
        applyStimulus(3'd0, 32'h0005_0003);
        checkOutput("load_a1x", {16'd0, a1_x}, 32'd3);
        checkOutput("load_a1y", {16'd0, a1_y}, 32'd5);

        // ---------------- 2-D walk, 3 pixels x 2 lines ----------------
        applyStimulus(3'd0, 32'h0000_0000);
        applyStimulus(3'd1, 32'h0000_0000);
        applyStimulus(3'd2, 32'h0000_0001);
        applyStimulus(3'd3, 32'h0000_0000);
        applyStimulus(3'd4, 32'h0001_FFFD);
        applyStimulus(3'd5, 32'h0000_0000);
        applyStimulus(3'd6, 32'h0001_FFFD);
        applyStimulus(3'd7, 32'h0002_0003);
        pix_ack = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        checkOutput("walk_first_req", {30'd0, pix_req, busy}, 32'h3);
        checkOutput("walk_first_a1x", {16'd0, a1_x}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                ld_en   = 1'b1;
                ld_sel  = 3'd0;
                ld_data = 32'h0005_0003;
            end
            tick();
            ld_en = 1'b0;
            checkOutput($sformatf("walk%0d_a1x", k), {16'd0, a1_x}, walkX[k]);
            checkOutput($sformatf("walk%0d_a1y", k), {16'd0, a1_y}, walkY[k]);
            checkOutput($sformatf("walk%0d_a2x", k), {16'd0, a2_x}, walkX[k]);
            checkOutput($sformatf("walk%0d_a2y", k), {16'd0, a2_y}, walkY[k]);
            checkOutput($sformatf("walk%0d_req", k), {31'd0, pix_req}, walkReq[k]);
            checkOutput($sformatf("walk%0d_busy", k), {31'd0, busy}, walkBusy[k]);
            checkOutput($sformatf("walk%0d_done", k), {31'd0, done}, walkDone[k]);
        end
        pix_ack = 1'b0;

        // ---------------- fraction carry + stall ----------------
        applyStimulus(3'd0, 32'h0000_0007);
        applyStimulus(3'd1, 32'h0000_C000);
        applyStimulus(3'd3, 32'h0000_8000);
        applyStimulus(3'd2, 32'h0000_0000);
        applyStimulus(3'd7, 32'h0001_0001);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 0; s < 5; s++) begin
            checkOutput($sformatf("stall%0d_req", s), {31'd0, pix_req}, 32'd1);
            checkOutput($sformatf("stall%0d_ptr", s), {a1_x, a1_frac_x}, 32'h0007_C000);
            tick();
        end
        pix_ack = 1'b1;
        tick();
        pix_ack = 1'b0;
        checkOutput("carry_a1x", {16'd0, a1_x}, 32'd8);
        checkOutput("carry_frac", {16'd0, a1_frac_x}, 32'h4000);
        checkOutput("carry_a1y", {a1_y, a1_frac_y}, 32'd0);
        checkOutput("carry_a2x", {16'd0, a2_x}, 32'd4);
        checkOutput("carry_done", {31'd0, done}, 32'd1);
        tick();

        // ---------------- 16-bit wrap ----------------
        applyStimulus(3'd0, 32'h0000_FFFF);
        applyStimulus(3'd1, 32'h0000_0000);
        applyStimulus(3'd3, 32'h0000_0000);
        applyStimulus(3'd2, 32'h0000_0001);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("wrap_pre", {16'd0, a1_x}, 32'h0000_FFFF);
        pix_ack = 1'b1;
        tick();
        pix_ack = 1'b0;
        checkOutput("wrap_a1x", {16'd0, a1_x}, 32'h0000_0000);
        checkOutput("wrap_a2x", {16'd0, a2_x}, 32'd5);
        tick();

        // ---------------- zero count ----------------
        applyStimulus(3'd7, 32'h0001_0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("zero_flags", {29'd0, pix_req, busy, done}, 32'h1);
        checkOutput("zero_a1x", {16'd0, a1_x}, 32'd0);
        tick();
        checkOutput("zero_after", {29'd0, pix_req, busy, done}, 32'h0);

        // ---------------- start with a COUNT load in the same cycle ----------------
        start   = 1'b1;
        ld_en   = 1'b1;
        ld_sel  = 3'd7;
        ld_data = 32'h0001_0001;
        tick();
        start   = 1'b0;
        ld_en   = 1'b0;
        checkOutput("startld_flags", {29'd0, pix_req, busy, done}, 32'h1);
        tick();

        // ---------------- asynchronous reset mid-blit ----------------
        applyStimulus(3'd0, 32'h0002_0009);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("midrst_pre", {29'd0, pix_req, busy, done}, 32'h6);
        #2;
        resetl = 1'b0;
        #1;
        checkOutput("midrst_ptrs", {a1_y, a1_x}, 32'd0);
        checkOutput("midrst_a2", {a2_y, a2_x}, 32'd0);
        checkOutput("midrst_flags", {29'd0, pix_req, busy, done}, 32'h0);
        tick();
        resetl = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("postrst_done", {29'd0, pix_req, busy, done}, 32'h1);
        tick();
        checkOutput("postrst_idle", {29'd0, pix_req, busy, done}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
